// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage of the 16-bit RISC core.
// Holds the PC and a synchronous-read instruction memory, presents one instruction at a time
// to the datapath and resolves BEQ/BNE/JMP redirects locally. A HALT opcode parks the unit
// until reset.
module inst_fetch_unit #(
   parameter int unsigned ADDR_W  = 8,
   parameter logic [3:0]  BEQ_OP  = 4'hB,
   parameter logic [3:0]  BNE_OP  = 4'hC,
   parameter logic [3:0]  JMP_OP  = 4'hD,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetchNextInst,
   input  logic              branch_resolved,
   input  logic              branch_taken,
   input  logic              imem_we,
   input  logic [ADDR_W-1:0] imem_waddr,
   input  logic [15:0]       imem_wdata,
   output logic [15:0]       instruction,
   output logic              readInst_flag,
   output logic              branchInst_flag,
   output logic [15:0]       pc,
   output logic              halted
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      StFetch,
      StIssue,
      StWait,
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic        branch_flag_q, branch_flag_d;
   logic        fetch_prev_q;

   logic [15:0] imem [Depth];
   logic [15:0] imem_rdata;
   logic [3:0]  cur_opcode;
   logic [15:0] branch_offset;
   logic        fetch_rise;
   logic        is_cond_branch;

   // Program load port; the memory deliberately has no reset.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         imem[imem_waddr] <= imem_wdata;
      end
   end

   // Upper PC bits alias onto the memory index. The read data is only captured into
   // instr_q in FETCH, so a same-edge write to that address returns the old word.
   assign imem_rdata = imem[pc_q[ADDR_W-1:0]];

   assign cur_opcode     = instr_q[15:12];
   assign branch_offset  = {{10{instr_q[5]}}, instr_q[5:0]};
   assign fetch_rise     = fetchNextInst & ~fetch_prev_q;
   assign is_cond_branch = (cur_opcode == BEQ_OP) || (cur_opcode == BNE_OP);

   // Next-state, PC and instruction register update.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      branch_flag_d = 1'b0;
      unique case (state_q)
         StFetch: begin
            // A HALT word is never presented to the datapath; the previous instruction stays.
            if (imem_rdata[15:12] == HALT_OP) begin
               state_d = StHalt;
            end else begin
               instr_d = imem_rdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            // Only the rule for the current opcode is consulted; the other event is dropped.
            if (is_cond_branch) begin
               if (branch_resolved) begin
                  pc_d          = branch_taken ? (pc_q + 16'd1 + branch_offset)
                                               : (pc_q + 16'd1);
                  branch_flag_d = 1'b1;
                  state_d       = StFetch;
               end
            end else if (cur_opcode == JMP_OP) begin
               pc_d          = {pc_q[15:12], instr_q[11:0]};
               branch_flag_d = 1'b1;
               state_d       = StFetch;
            end else if (fetch_rise) begin
               pc_d    = pc_q + 16'd1;
               state_d = StFetch;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // State registers; fetch_prev_q tracks the done level every cycle in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StFetch;
         pc_q          <= 16'h0000;
         instr_q       <= 16'h0000;
         branch_flag_q <= 1'b0;
         fetch_prev_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         branch_flag_q <= branch_flag_d;
         fetch_prev_q  <= fetchNextInst;
      end
   end

   assign instruction     = instr_q;
   assign pc              = pc_q;
   assign branchInst_flag = branch_flag_q;
   assign readInst_flag   = (state_q == StIssue);
   assign halted          = (state_q == StHalt);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a driver walks a program model, pushes the expected
// (pc, instruction) of every issue, and an independent monitor pops and compares.
module tb_inst_fetch_unit;

   localparam logic [3:0] OpBeq  = 4'hB;
   localparam logic [3:0] OpBne  = 4'hC;
   localparam logic [3:0] OpJmp  = 4'hD;
   localparam logic [3:0] OpHalt = 4'hF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetchNextInst = 1'b0;
   logic        branch_resolved = 1'b0;
   logic        branch_taken = 1'b0;
   logic        imem_we = 1'b0;
   logic [7:0]  imem_waddr = 8'h00;
   logic [15:0] imem_wdata = 16'h0000;
   logic [15:0] instruction;
   logic        readInst_flag;
   logic        branchInst_flag;
   logic [15:0] pc;
   logic        halted;

   inst_fetch_unit #(
      .ADDR_W (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fetchNextInst   (fetchNextInst),
      .branch_resolved (branch_resolved),
      .branch_taken    (branch_taken),
      .imem_we         (imem_we),
      .imem_waddr      (imem_waddr),
      .imem_wdata      (imem_wdata),
      .instruction     (instruction),
      .readInst_flag   (readInst_flag),
      .branchInst_flag (branchInst_flag),
      .pc              (pc),
      .halted          (halted)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   bit          taken_q[$];
   int          hold_q[$];
   logic [15:0] mmem [256];
   logic [15:0] mpc;
   logic [15:0] cur_ins;
   bit          halt_pending;
   bit          rewrite_hook;
   int          checks = 0;
   int          failures = 0;
   int          issue_cnt = 0;
   int          consumed = 0;
   int          br_cnt = 0;
   int          exp_br = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every issue pops one expectation; both flags must be single-cycle pulses.
   initial begin
      exp_t e;
      bit   rd_prev = 1'b0;
      bit   br_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (readInst_flag) begin
               issue_cnt++;
               chk("issue_width", 16'(rd_prev), 16'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL issue_unexpected actual_pc=%h required=no_issue", pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("issue_pc", pc, e.pc);
                  chk("issue_instr", instruction, e.instr);
               end
            end
            if (branchInst_flag) begin
               br_cnt++;
               chk("branch_width", 16'(br_prev), 16'h0);
            end
         end
         rd_prev = readInst_flag;
         br_prev = branchInst_flag;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic write_mem(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      imem_we    = 1'b1;
      imem_waddr = a;
      imem_wdata = d;
      mmem[a]    = d;
      @(negedge clk);
      imem_we    = 1'b0;
   endtask

   // Move the model PC and predict what the next FETCH produces.
   task automatic expect_next(input logic [15:0] nxt);
      exp_t e;
      mpc = nxt;
      if (mmem[nxt[7:0]][15:12] == OpHalt) begin
         halt_pending = 1'b1;
      end else begin
         e.pc    = nxt;
         e.instr = mmem[nxt[7:0]];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_issue(output bit ok);
      int n = 0;
      while (issue_cnt <= consumed && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = (issue_cnt > consumed);
      if (ok) begin
         consumed++;
      end else begin
         checks++;
         failures++;
         $display("FAIL issue_timeout actual=none required=issue_at_pc_%h", mpc);
      end
   endtask

   // Asynchronous reset in the middle of the high phase, then release on a falling edge.
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pc", pc, 16'h0);
      chk("rst_instr", instruction, 16'h0);
      chk("rst_read", 16'(readInst_flag), 16'h0);
      chk("rst_branch", 16'(branchInst_flag), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_queue_empty", 16'(exp_q.size()), 16'h0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset        = 1'b0;
      halt_pending = 1'b0;
      expect_next(16'h0000);
      @(negedge clk);
      #1;
      chk("issue_cycle2", 16'(readInst_flag), 16'h1);
   endtask

   task automatic do_halt();
      int base = issue_cnt;
      for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
      chk("halted", 16'(halted), 16'h1);
      chk("halt_pc", pc, mpc);
      chk("halt_instr", instruction, cur_ins);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         fetchNextInst   = 1'b1;
         branch_resolved = 1'b1;
         branch_taken    = 1'b1;
         @(negedge clk);
         fetchNextInst   = 1'b0;
         branch_resolved = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("halt_hold_pc", pc, mpc);
      chk("halt_no_issue", 16'(issue_cnt - base), 16'h0);
      chk("halt_still", 16'(halted), 16'h1);
   endtask

   task automatic step(output bit stop);
      logic [15:0] ins;
      logic [15:0] nxt;
      logic [3:0]  op;
      logic [3:0]  nop;
      bit          ok;
      bit          tk;
      int          h;
      int          off;
      stop = 1'b0;
      wait_issue(ok);
      if (!ok) begin
         stop = 1'b1;
         return;
      end
      ins     = mmem[mpc[7:0]];
      cur_ins = ins;
      op      = ins[15:12];
      if (rewrite_hook && mpc == 16'h0FFE) begin
         write_mem(8'h01, 16'hC00E);
         rewrite_hook = 1'b0;
      end
      if (op == OpBeq || op == OpBne) begin
         tk  = (taken_q.size() != 0) ? taken_q.pop_front() : bit'($urandom % 2);
         off = int'($signed(ins[5:0]));
         nxt = tk ? 16'(int'(mpc) + 1 + off) : 16'(int'(mpc) + 1);
         expect_next(nxt);
         repeat ($urandom % 3) @(negedge clk);
         if ($urandom % 2 == 1) begin
            @(negedge clk);
            fetchNextInst = 1'b1;
            @(negedge clk);
            fetchNextInst = 1'b0;
         end
         @(negedge clk);
         branch_resolved = 1'b1;
         branch_taken    = tk;
         @(negedge clk);
         branch_resolved = 1'b0;
         branch_taken    = bit'($urandom % 2);
         exp_br++;
         chk("branch_flag", 16'(branchInst_flag), 16'h1);
         chk("branch_pc", pc, nxt);
      end else if (op == OpJmp) begin
         nxt = {mpc[15:12], ins[11:0]};
         expect_next(nxt);
         exp_br++;
         @(negedge clk);
         @(negedge clk);
         chk("jmp_flag", 16'(branchInst_flag), 16'h1);
         chk("jmp_pc", pc, nxt);
      end else begin
         nxt = 16'(int'(mpc) + 1);
         nop = mmem[nxt[7:0]][15:12];
         h   = (hold_q.size() != 0) ? hold_q.pop_front() : 1 + int'($urandom % 4);
         if (nop == OpBeq || nop == OpBne || nop == OpJmp || nop == OpHalt) h = 1;
         if ($urandom % 3 == 0) begin
            @(negedge clk);
            branch_resolved = 1'b1;
            branch_taken    = 1'b1;
            @(negedge clk);
            branch_resolved = 1'b0;
            chk("ignore_resolved_pc", pc, mpc);
         end
         expect_next(nxt);
         @(negedge clk);
         fetchNextInst = 1'b1;
         @(negedge clk);
         chk("advance_pc", pc, nxt);
         repeat (h - 1) @(negedge clk);
         fetchNextInst = 1'b0;
         if (h > 1) chk("hold_pc", pc, nxt);
      end
   endtask

   task automatic run(input int max_steps, output bit hit_halt, output bit stop);
      hit_halt = 1'b0;
      stop     = 1'b0;
      for (int i = 0; i < max_steps; i++) begin
         step(stop);
         if (stop) return;
         if (halt_pending) begin
            do_halt();
            hit_halt = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      bit          hh;
      bit          st;
      logic [15:0] w;
      reset = 1'b1;
      rewrite_hook = 1'b0;

      // Sequential, level hold, BEQ taken/not taken, BNE, HALT.
      for (int a = 0; a < 256; a++) write_mem(8'(a), 16'h0000);
      write_mem(8'h00, 16'h1298);
      write_mem(8'h01, 16'h2450);
      write_mem(8'h02, 16'h3000);
      write_mem(8'h03, 16'h4111);
      write_mem(8'h04, 16'hB03E);
      write_mem(8'h05, 16'hC001);
      write_mem(8'h06, 16'hF000);
      write_mem(8'h07, 16'hF000);
      taken_q = '{1'b1, 1'b0, 1'b1};
      hold_q  = '{1, 6};
      do_reset();
      run(20, hh, st);
      chk("phase_a_halt", 16'(hh), 16'h1);

      // Wrap through 0xFFFF, JMP keeping pc[15:12], BNE into 0x1010, JMP to 0x1020.
      write_mem(8'h00, 16'hB03E);
      write_mem(8'h01, 16'hDFFE);
      write_mem(8'hFE, 16'h6000);
      write_mem(8'hFF, 16'h6001);
      write_mem(8'h10, 16'hD020);
      write_mem(8'h20, 16'hF000);
      taken_q      = '{1'b1, 1'b0, 1'b0, 1'b1};
      rewrite_hook = 1'b1;
      if (!st) begin
         do_reset();
         run(20, hh, st);
         chk("phase_b_halt_pc", mpc, 16'h1020);
      end

      // HALT at pc 2, then reset while halted and refetch from 0.
      write_mem(8'h00, 16'h1298);
      write_mem(8'h01, 16'h2450);
      write_mem(8'h02, 16'hF000);
      if (!st) begin
         do_reset();
         run(10, hh, st);
         chk("phase_c_halt_pc", mpc, 16'h0002);
      end
      if (!st) begin
         do_reset();
         run(10, hh, st);
      end

      // Random programs.
      for (int a = 0; a < 256; a++) begin
         w = 16'($urandom);
         if (w[15:12] == OpHalt && ($urandom % 6 != 0 || a == 0)) w[15:12] = 4'h0;
         write_mem(8'(a), w);
      end
      taken_q.delete();
      hold_q.delete();
      for (int r = 0; r < 6 && !st; r++) begin
         do_reset();
         run(80, hh, st);
         while (!hh && !st) run(80, hh, st);
         if (r >= 3 && !hh) break;
      end

      repeat (20) @(negedge clk);
      chk("final_queue_empty", 16'(exp_q.size()), 16'h0);
      chk("branch_pulse_count", 16'(br_cnt), 16'(exp_br));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage of the 16-bit RISC core, directly upstream of the datapath unit.
- Holds the program counter and a synchronous-read instruction memory.
- Presents one instruction at a time on `instruction`, pulsing `readInst_flag`, then waits for the datapath's completion level (`fetchNextInst`) or a branch resolution before advancing.
- Resolves conditional branches and unconditional jumps itself and signals redirection on `branchInst_flag`.

## Interface
- `ADDR_W`, 8: instruction memory index width; depth = 2^ADDR_W words.
- `BEQ_OP`, 4'hB: opcode of branch-if-equal.
- `BNE_OP`, 4'hC: opcode of branch-if-not-equal.
- `JMP_OP`, 4'hD: opcode of unconditional jump.
- `HALT_OP`, 4'hF: opcode that stops fetch.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `fetchNextInst` in 1: datapath done-level; only its rising edge counts.
- `branch_resolved` in 1: one-cycle pulse from ALU; the compare result for the pending BEQ/BNE is valid.
- `branch_taken` in 1: qualified by `branch_resolved`; 1 means take the branch.
- `imem_we` in 1: instruction memory write enable (program load).
- `imem_waddr` in ADDR_W: write address.
- `imem_wdata` in 16: write data.
- `instruction` out 16: current instruction; stable from ISSUE until the next FETCH completes.
- `readInst_flag` out 1: one-cycle pulse, high while in ISSUE.
- `branchInst_flag` out 1: one-cycle pulse when a BEQ/BNE/JMP redirect is applied.
- `pc` out 16: address of the instruction on `instruction`.
- `halted` out 1: high in HALT.

## Operation
- Instruction fields: opcode [15:12]; branch offset [5:0], signed; jump field [11:0].
- Memory read index is `pc[ADDR_W-1:0]`; upper PC bits alias.
- Memory has no reset. A write lands at the clock edge.
- A same-cycle write and read to one address returns the old data.
- Writes are permitted in any state.
- FSM states: FETCH, ISSUE, WAIT, HALT. Reset state is FETCH.
- FETCH:
  - Register `imem[pc]` into `instruction`.
  - If the fetched opcode is HALT_OP, go to HALT with `instruction` unchanged.
  - Otherwise go to ISSUE.
- ISSUE: `readInst_flag` = 1 for this cycle; go to WAIT.
- WAIT, current opcode BEQ_OP or BNE_OP:
  - Wait for `branch_resolved`.
  - Taken: pc ← pc + 1 + sext(offset6). Not taken: pc ← pc + 1.
  - Pulse `branchInst_flag`; go to FETCH.
  - `fetchNextInst` is ignored.
- WAIT, current opcode JMP_OP: on the first WAIT cycle, pc ← {pc[15:12], instruction[11:0]}; pulse `branchInst_flag`; go to FETCH.
- WAIT, any other opcode:
  - On a rising edge of `fetchNextInst` (i.e. `fetchNextInst` & ~`fetchNextInst_d`), pc ← pc + 1; go to FETCH.
  - `branch_resolved` is ignored.
- HALT: absorbing. All inputs except `imem_*` are ignored; pc holds the HALT address. Only reset exits.
- PC arithmetic is 16-bit modulo 2^16: 16'hFFFF + 1 = 0; negative offsets wrap.
- `fetchNextInst_d` is a register that updates every cycle in every state. A level already high on entering WAIT does not advance; a new rise is required.
- Simultaneous `fetchNextInst` rise and `branch_resolved`: the rule matching the current opcode wins; the other is dropped.

## Timing
- Reset values: `pc`=0, `instruction`=0, `readInst_flag`=0, `branchInst_flag`=0, `halted`=0, `fetchNextInst_d`=0, state FETCH.
- Reset acts immediately (asynchronously) from any state, including mid-WAIT.
- After reset release:
  - Cycle 1: FETCH.
  - Cycle 2: ISSUE; `readInst_flag`=1, `instruction`=imem[0].
- Advance latency: `fetchNextInst` rise sampled at edge N → pc updates at edge N → FETCH during cycle N+1 → `readInst_flag` high during cycle N+2 with the new instruction.
- Branch: `branch_resolved` sampled at edge N → `pc` and `branchInst_flag` updated at edge N. `branchInst_flag` is high for cycle N+1 only; FETCH also occurs in cycle N+1. ISSUE follows in cycle N+2.
- JMP: ISSUE at cycle k, WAIT at k+1, redirect at the end of k+1. `branchInst_flag` high in k+2; ISSUE at k+3.
- `halted` rises the cycle after HALT_OP is fetched; no `readInst_flag` pulse is produced for HALT_OP.

## Test plan
- Sequential: imem[0]=16'h1298, imem[1]=16'h2450, reset → `readInst_flag` in cycle 2 with `instruction`=16'h1298, `pc`=0. Then a `fetchNextInst` rise → `pc`=1, `instruction`=16'h2450, `readInst_flag` two cycles later.
- Level hold: `fetchNextInst` held high 6 cycles → exactly one advance; pc goes 1→2 only.
- BEQ at pc=4 with offset 6'b111110:
  - `branch_resolved`=1, `branch_taken`=1 → `pc`=3 and one `branchInst_flag` pulse.
  - Repeat with `branch_taken`=0 → `pc`=5.
  - A `fetchNextInst` rise during WAIT causes no change.
- JMP 16'hD020 at pc=16'h1010 → `pc`=16'h1020 and a `branchInst_flag` pulse with no `fetchNextInst`.
- Wrap: pc=16'hFFFF with a non-branch instruction, `fetchNextInst` rise → `pc`=0.
- HALT 16'hF000 at pc=2 → `halted`=1, `pc` stays 2, no `readInst_flag`, `fetchNextInst` pulses ignored. Then async `reset` asserted mid-cycle → all outputs 0 at once; after release, refetch from 0.
